sent_tx_crc_gen: RTL and testbench

Bit-serial CRC generator for the SENT transmitter, the transmit-side counterpart of the receive CRC check. On a start pulse it latches a mode and a data word, runs the SAE J2716 seeded division one bit per clock, and returns the CRC nibble (CRC4) or 6-bit CRC (CRC6) to the TX frame builder. The frame builder appends the result to the fast-channel frame or to the serial message. Codes and word layouts match the receive checker exactly, so any generated frame is accepted by the RX CRC check.

---
 rtl/sent_tx_crc_gen_pkg.sv | 59 +++++
 rtl/sent_tx_crc_gen_if.sv | 47 ++++
 rtl/sent_tx_crc_gen_lfsr.sv | 66 ++++++
 rtl/sent_tx_crc_gen.sv | 153 +++++++++++++++
 tb/tb_sent_tx_crc_gen.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sent_tx_crc_gen_pkg.sv
// sent_tx_pkg: constants shared by the SENT TX CRC generator.
//   Mode codes, CRC4/CRC6 seeds and polynomials, the FSM state encoding,
//   and small helpers that map a mode code to its data length.
//   Configuration macro: SENT_TX_CRC_ENHANCED_EN (enables mode 101, CRC6).
package sent_tx_pkg;

  localparam logic [2:0] CRC_MODE_FAST   = 3'b001;
  localparam logic [2:0] CRC_MODE_CH16   = 3'b010;
  localparam logic [2:0] CRC_MODE_CH12   = 3'b011;
  localparam logic [2:0] CRC_MODE_SERIAL = 3'b100;
  localparam logic [2:0] CRC_MODE_ENH    = 3'b101;

  localparam logic [3:0] CRC4_SEED = 4'b0101;
  localparam logic [5:0] CRC6_SEED = 6'b010101;

  // x^4 and x^6 terms are implicit; these are the low-order feedback taps.
  localparam logic [3:0] CRC4_POLY = 4'b1101;
  localparam logic [5:0] CRC6_POLY = 6'b011001;

  localparam int CRC_CNT_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } crc_state_e;

  // Number of message bits fed into the division for a mode code.
  function automatic logic [CRC_CNT_W-1:0] crc_data_bits(input logic [2:0] mode);
    logic [CRC_CNT_W-1:0] n;
    case (mode)
      CRC_MODE_FAST:   n = 5'd24;
      CRC_MODE_CH16:   n = 5'd16;
      CRC_MODE_CH12:   n = 5'd12;
      CRC_MODE_SERIAL: n = 5'd12;
      CRC_MODE_ENH:    n = 5'd24;
      default:         n = 5'd0;
    endcase
    return n;
  endfunction

  // Places the selected data slice at the top of the 24-bit shift register.
  function automatic logic [23:0] crc_align_data(input logic [2:0]  mode,
                                                 input logic [23:0] fast,
                                                 input logic [23:0] chan);
    logic [23:0] d;
    case (mode)
      CRC_MODE_FAST:   d = fast;
      CRC_MODE_CH16:   d = {chan[15:0], 8'h00};
      CRC_MODE_CH12:   d = {chan[11:0], 12'h000};
      CRC_MODE_SERIAL: d = {chan[11:0], 12'h000};
      CRC_MODE_ENH:    d = chan;
      default:         d = 24'h000000;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/sent_tx_crc_gen_if.sv
// sent_tx_crc_gen_if: request/result bundle between the TX frame builder
// and the CRC generator.
//   master : frame builder (drives start, mode, data; receives results)
//   slave  : CRC generator
//   crc_gen_start        one-cycle request
//   enable_crc_gen       mode code
//   data_fast_gen_crc    fast-channel nibbles 1..6, MSB first
//   data_channel_gen_crc serial/channel data, right-aligned
//   crc_gen_busy         high in LOAD and SHIFT
//   crc_gen_done         one-cycle result strobe
//   crc_gen_error        one-cycle strobe with done on an illegal mode
//   crc_value            result, held between runs
//   Configuration macro: SENT_TX_CRC_ENHANCED_EN (no effect on this file).
interface sent_tx_crc_gen_if;

  logic        crc_gen_start;
  logic [2:0]  enable_crc_gen;
  logic [23:0] data_fast_gen_crc;
  logic [23:0] data_channel_gen_crc;
  logic        crc_gen_busy;
  logic        crc_gen_done;
  logic        crc_gen_error;
  logic [5:0]  crc_value;

  modport master (
    output crc_gen_start,
    output enable_crc_gen,
    output data_fast_gen_crc,
    output data_channel_gen_crc,
    input  crc_gen_busy,
    input  crc_gen_done,
    input  crc_gen_error,
    input  crc_value
  );

  modport slave (
    input  crc_gen_start,
    input  enable_crc_gen,
    input  data_fast_gen_crc,
    input  data_channel_gen_crc,
    output crc_gen_busy,
    output crc_gen_done,
    output crc_gen_error,
    output crc_value
  );

endinterface

// File: rtl/sent_tx_crc_gen_lfsr.sv
// sent_crc_lfsr: remainder register for the seeded SAE J2716 CRC division.
//   clk, rst_n : clock, async active-low reset
//   seed_load  : load the seed for the selected width
//   step       : shift in bit_in and apply polynomial feedback
//   crc6_sel   : 1 = 6-bit CRC, 0 = 4-bit CRC (present only with the macro)
//   bit_in     : next message/augment bit
//   rem        : current remainder, CRC4 zero-extended into [5:4]
//   Configuration macro: SENT_TX_CRC_ENHANCED_EN. When undefined the
//   register is 4 bits wide and rem[5:4] are tied to 0.
module sent_crc_lfsr
  import sent_tx_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       seed_load,
  input  logic       step,
`ifdef SENT_TX_CRC_ENHANCED_EN
  input  logic       crc6_sel,
`endif
  input  logic       bit_in,
  output logic [5:0] rem
);

`ifdef SENT_TX_CRC_ENHANCED_EN
  logic [5:0] rem_q, rem_d;

  always_comb begin
    rem_d = rem_q;
    if (seed_load) begin
      rem_d = crc6_sel ? CRC6_SEED : {2'b00, CRC4_SEED};
    end else if (step) begin
      if (crc6_sel) begin
        rem_d = {rem_q[4:0], bit_in} ^ (rem_q[5] ? CRC6_POLY : 6'd0);
      end else begin
        rem_d = {2'b00, ({rem_q[2:0], bit_in} ^ (rem_q[3] ? CRC4_POLY : 4'd0))};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rem_q <= 6'd0;
    else        rem_q <= rem_d;
  end

  assign rem = rem_q;
`else
  logic [3:0] rem_q, rem_d;

  always_comb begin
    rem_d = rem_q;
    if (seed_load) begin
      rem_d = CRC4_SEED;
    end else if (step) begin
      rem_d = {rem_q[2:0], bit_in} ^ (rem_q[3] ? CRC4_POLY : 4'd0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rem_q <= 4'd0;
    else        rem_q <= rem_d;
  end

  assign rem = {2'b00, rem_q};
`endif

endmodule

// File: rtl/sent_tx_crc_gen.sv
// sent_tx_crc_gen: bit-serial CRC generator for the SENT transmitter.
//   clk_tx     : TX clock
//   reset_n_tx : async active-low reset
//   crc_if     : slave side of sent_tx_crc_gen_if (start/mode/data in,
//                busy/done/error/crc_value out, all outputs registered)
//   Configuration macro: SENT_TX_CRC_ENHANCED_EN. Defined: mode 101
//   (CRC6 over 24 bits) is legal. Undefined: mode 101 is an illegal mode.
//
//   state    | meaning
//   ---------+-------------------------------------------------------
//   ST_IDLE  | waiting for crc_gen_start; latches mode and data
//   ST_LOAD  | checks mode, seeds remainder, loads bit counter N+W
//   ST_SHIFT | one division step per clock until the counter hits 0
//   ST_DONE  | publishes crc_value (0 on illegal mode), pulses done
module sent_tx_crc_gen
  import sent_tx_pkg::*;
(
  input  logic               clk_tx,
  input  logic               reset_n_tx,
  sent_tx_crc_gen_if.slave   crc_if
);

  crc_state_e           state_q, state_d;
  logic [2:0]           mode_q, mode_d;
  logic [23:0]          sr_q, sr_d;
  logic [CRC_CNT_W-1:0] cnt_q, cnt_d;
  logic                 ill_q, ill_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 error_q, error_d;
  logic [5:0]           crc_q, crc_d;

  logic                 mode_legal;
  logic                 crc6_sel;
  logic [CRC_CNT_W-1:0] n_bits;
  logic [CRC_CNT_W-1:0] w_bits;
  logic                 seed_load;
  logic                 step;
  logic                 bit_in;
  logic [5:0]           rem;

`ifdef SENT_TX_CRC_ENHANCED_EN
  assign crc6_sel   = (mode_q == CRC_MODE_ENH);
  assign mode_legal = (mode_q >= CRC_MODE_FAST) && (mode_q <= CRC_MODE_ENH);
`else
  assign crc6_sel   = 1'b0;
  assign mode_legal = (mode_q >= CRC_MODE_FAST) && (mode_q <= CRC_MODE_SERIAL);
`endif

  assign n_bits = crc_data_bits(mode_q);
  assign w_bits = crc6_sel ? 5'd6 : 5'd4;

  sent_crc_lfsr u_lfsr (
    .clk       (clk_tx),
    .rst_n     (reset_n_tx),
    .seed_load (seed_load),
    .step      (step),
`ifdef SENT_TX_CRC_ENHANCED_EN
    .crc6_sel  (crc6_sel),
`endif
    .bit_in    (bit_in),
    .rem       (rem)
  );

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    ill_d     = ill_q;
    crc_d     = crc_q;
    done_d    = 1'b0;
    error_d   = 1'b0;
    seed_load = 1'b0;
    step      = 1'b0;
    bit_in    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (crc_if.crc_gen_start) begin
          mode_d  = crc_if.enable_crc_gen;
          sr_d    = crc_align_data(crc_if.enable_crc_gen,
                                   crc_if.data_fast_gen_crc,
                                   crc_if.data_channel_gen_crc);
          state_d = ST_LOAD;
        end
      end

      ST_LOAD: begin
        if (!mode_legal) begin
          ill_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          ill_d     = 1'b0;
          cnt_d     = n_bits + w_bits;
          seed_load = 1'b1;
          state_d   = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        step   = 1'b1;
        // Counter above W means message bits remain; the last W steps
        // feed the zero augment.
        bit_in = (cnt_q > w_bits) ? sr_q[23] : 1'b0;
        sr_d   = {sr_q[22:0], 1'b0};
        cnt_d  = cnt_q - 5'd1;
        if (cnt_q == 5'd1) state_d = ST_DONE;
      end

      ST_DONE: begin
        done_d  = 1'b1;
        error_d = ill_q;
        crc_d   = ill_q ? 6'd0 : rem;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_LOAD) || (state_d == ST_SHIFT);
  end

  always_ff @(posedge clk_tx or negedge reset_n_tx) begin
    if (!reset_n_tx) begin
      state_q <= ST_IDLE;
      mode_q  <= 3'd0;
      sr_q    <= 24'd0;
      cnt_q   <= '0;
      ill_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      crc_q   <= 6'd0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      ill_q   <= ill_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
      crc_q   <= crc_d;
    end
  end

  assign crc_if.crc_gen_busy  = busy_q;
  assign crc_if.crc_gen_done  = done_q;
  assign crc_if.crc_gen_error = error_q;
  assign crc_if.crc_value     = crc_q;

endmodule

// File: tb/tb_sent_tx_crc_gen.sv
// Testbench for sent_tx_crc_gen: directed vectors plus seeded random words,
// expected results queued at stimulus time and checked by a monitor on done.
// Honours SENT_TX_CRC_ENHANCED_EN for the expected behaviour of mode 101.
module tb_sent_tx_crc_gen;
  import sent_tx_pkg::*;

  logic clk_tx     = 1'b0;
  logic reset_n_tx = 1'b0;
  int   cyc        = 0;
  int   errors     = 0;
  int   checks     = 0;
  logic [5:0] last_crc = 6'd0;

  sent_tx_crc_gen_if crc_if();

  sent_tx_crc_gen dut (
    .clk_tx     (clk_tx),
    .reset_n_tx (reset_n_tx),
    .crc_if     (crc_if)
  );

  always #5 clk_tx = ~clk_tx;
  always @(posedge clk_tx) cyc <= cyc + 1;

  typedef struct {
    logic [5:0]  crc;
    logic        err;
    int          due;
    logic [2:0]  mode;
    logic [23:0] fast;
    logic [23:0] ch;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit exp_legal(input logic [2:0] mode);
`ifdef SENT_TX_CRC_ENHANCED_EN
    return (mode >= 3'd1) && (mode <= 3'd5);
`else
    return (mode >= 3'd1) && (mode <= 3'd4);
`endif
  endfunction

  // Seeded long division: n message bits MSB first, then W tail bits
  // (zeros to generate, the CRC itself to check on the receive side).
  function automatic logic [5:0] model_crc(input logic [2:0] mode, input logic [23:0] fast,
                                           input logic [23:0] ch, input logic [5:0] tail);
    int n; int w; logic [23:0] d; logic [5:0] r; logic [5:0] p; logic b; logic top;
    case (mode)
      3'd1:    begin n = 24; d = fast; end
      3'd2:    begin n = 16; d = {8'h00, ch[15:0]}; end
      3'd3,
      3'd4:    begin n = 12; d = {12'h000, ch[11:0]}; end
      3'd5:    begin n = 24; d = ch; end
      default: begin n = 0;  d = 24'h0; end
    endcase
    w = (mode == 3'd5) ? 6 : 4;
    r = (w == 6) ? 6'h15 : 6'h05;
    p = (w == 6) ? 6'h19 : 6'h0D;
    for (int i = 0; i < n + w; i++) begin
      b   = (i < n) ? d[n-1-i] : tail[w-1-(i-n)];
      top = r[w-1];
      r   = {r[4:0], b};
      if (w == 4) r[5:4] = 2'b00;
      if (top) r = r ^ p;
    end
    return r;
  endfunction

  function automatic int lat_of(input logic [2:0] mode);
    if (!exp_legal(mode)) return 2;
    case (mode)
      3'd1:    return 30;
      3'd2:    return 22;
      3'd5:    return 32;
      default: return 18;
    endcase
  endfunction

  // Monitor: every done pulse consumes one queued expectation.
  always @(negedge clk_tx) begin
    exp_t e;
    if (reset_n_tx && crc_if.crc_gen_done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done with crc 0x%0h expected no done (cycle %0d)",
                 crc_if.crc_value, cyc);
      end else begin
        e = sb.pop_front();
        check($sformatf("crc_mode%0d", e.mode), {26'd0, crc_if.crc_value}, {26'd0, e.crc});
        check($sformatf("error_mode%0d", e.mode), {31'd0, crc_if.crc_gen_error}, {31'd0, e.err});
        check($sformatf("latency_mode%0d", e.mode), cyc, e.due);
        if (!e.err)
          check($sformatf("rx_accept_mode%0d", e.mode),
                {26'd0, model_crc(e.mode, e.fast, e.ch, crc_if.crc_value)}, 32'd0);
        last_crc = e.crc;
      end
    end else if (reset_n_tx && crc_if.crc_gen_error) begin
      checks++;
      errors++;
      $display("FAIL error_without_done: got error=1 done=0 expected error=0 (cycle %0d)", cyc);
    end
  end

  task automatic issue(input logic [2:0] mode, input logic [23:0] fast, input logic [23:0] ch,
                       input logic [5:0] exp_crc, input logic exp_err, input int lat);
    @(negedge clk_tx);
    crc_if.crc_gen_start        = 1'b1;
    crc_if.enable_crc_gen       = mode;
    crc_if.data_fast_gen_crc    = fast;
    crc_if.data_channel_gen_crc = ch;
    sb.push_back('{crc: exp_crc, err: exp_err, due: cyc + 1 + lat, mode: mode, fast: fast, ch: ch});
    @(negedge clk_tx);
    crc_if.crc_gen_start        = 1'b0;
    crc_if.enable_crc_gen       = 3'($urandom);
    crc_if.data_fast_gen_crc    = 24'($urandom);
    crc_if.data_channel_gen_crc = 24'($urandom);
  endtask

  task automatic issue_model(input logic [2:0] mode, input logic [23:0] fast, input logic [23:0] ch);
    logic legal;
    legal = exp_legal(mode);
    issue(mode, fast, ch, legal ? model_crc(mode, fast, ch, 6'd0) : 6'd0, !legal, lat_of(mode));
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk_tx);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got %0d pending results expected 0", sb.size());
      sb.delete();
    end
    @(negedge clk_tx);
    check("crc_held", {26'd0, crc_if.crc_value}, {26'd0, last_crc});
    check("busy_idle", {31'd0, crc_if.crc_gen_busy}, 32'd0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"},  {31'd0, crc_if.crc_gen_busy},  32'd0);
    check({tag, "_done"},  {31'd0, crc_if.crc_gen_done},  32'd0);
    check({tag, "_error"}, {31'd0, crc_if.crc_gen_error}, 32'd0);
    check({tag, "_crc"},   {26'd0, crc_if.crc_value},     32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    crc_if.crc_gen_start        = 1'b0;
    crc_if.enable_crc_gen       = 3'd0;
    crc_if.data_fast_gen_crc    = 24'd0;
    crc_if.data_channel_gen_crc = 24'd0;
    repeat (3) @(negedge clk_tx);
    check_outputs_zero("reset");
    reset_n_tx = 1'b1;
    repeat (2) @(negedge clk_tx);

    // Directed vectors with hand-derived results.
    issue(CRC_MODE_FAST, 24'h0, 24'h0, 6'h05, 1'b0, 30);
    check("busy_after_start", {31'd0, crc_if.crc_gen_busy}, 32'd1);
    wait_drain();
    issue(CRC_MODE_SERIAL, 24'h0, 24'h0, 6'h09, 1'b0, 18);
    wait_drain();
    issue(CRC_MODE_CH16, 24'h0, 24'h0, 6'h0C, 1'b0, 22);
    wait_drain();
    issue(CRC_MODE_CH12, 24'h0, 24'h0, 6'h09, 1'b0, 18);
    wait_drain();
`ifdef SENT_TX_CRC_ENHANCED_EN
    issue(CRC_MODE_ENH, 24'h0, 24'h0, 6'h26, 1'b0, 32);
`else
    issue(CRC_MODE_ENH, 24'h0, 24'h0, 6'h00, 1'b1, 2);
`endif
    wait_drain();
    issue(CRC_MODE_FAST, 24'h0, 24'h0, 6'h05, 1'b0, 30);
    wait_drain();
    issue(3'b111, 24'hFFFFFF, 24'hFFFFFF, 6'h00, 1'b1, 2);
    wait_drain();
    issue(3'b000, 24'h123456, 24'h654321, 6'h00, 1'b1, 2);
    wait_drain();
    issue(3'b110, 24'h0F0F0F, 24'hF0F0F0, 6'h00, 1'b1, 2);
    wait_drain();

    // Random words in every mode against the division model.
    for (int m = 1; m <= 5; m++) begin
      for (int k = 0; k < 40; k++) begin
        issue_model(3'(m), 24'($urandom), 24'($urandom));
        wait_drain();
      end
    end

    // A start while SHIFT is running must be dropped.
    issue_model(CRC_MODE_FAST, 24'hABCDEF, 24'h0);
    repeat (6) @(negedge clk_tx);
    crc_if.crc_gen_start        = 1'b1;
    crc_if.enable_crc_gen       = CRC_MODE_CH12;
    crc_if.data_channel_gen_crc = 24'h000FFF;
    @(negedge clk_tx);
    crc_if.crc_gen_start = 1'b0;
    wait_drain();
    repeat (40) @(negedge clk_tx);

    // Reset mid-SHIFT discards the run; no done may follow.
    @(negedge clk_tx);
    crc_if.crc_gen_start     = 1'b1;
    crc_if.enable_crc_gen    = CRC_MODE_FAST;
    crc_if.data_fast_gen_crc = 24'h123456;
    @(negedge clk_tx);
    crc_if.crc_gen_start = 1'b0;
    repeat (8) @(negedge clk_tx);
    check("busy_mid_shift", {31'd0, crc_if.crc_gen_busy}, 32'd1);
    reset_n_tx = 1'b0;
    #1;
    check_outputs_zero("mid_reset");
    @(negedge clk_tx);
    reset_n_tx = 1'b1;
    last_crc   = 6'd0;
    repeat (40) @(negedge clk_tx);
    issue_model(CRC_MODE_FAST, 24'h123456, 24'h0);
    wait_drain();
    issue_model(CRC_MODE_CH16, 24'h0, 24'h00BEEF);
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
